pinball_switch_conditioner: RTL
===============================

Name: pinball_switch_conditioner

Overview:
Upstream stage of the pinball scoring FSM. It takes raw, bouncy playfield switch contacts and turns them into clean one-cycle event pulses: GO/BOP/WHAM/BASH/WIPE_OUT hits, START_BALL on plunger launch, and a latched TILT level. Simultaneous hits are serialized one per cycle so that none are lost to the scorer's if/else priority.

Parameters:
DEB_CYCLES, 4, consecutive stable synced cycles required to accept a switch change
DEB_W, 3, width of each debounce counter; must satisfy 2^DEB_W > DEB_CYCLES
TILT_NUDGES, 3, nudge events inside one window that trigger TILT
TILT_WINDOW, 64, tilt window length in cycles, counted from the first nudge
WIN_W, 7, width of the window timer; must satisfy 2^WIN_W >= TILT_WINDOW

Ports:
CLK  in  1  system clock; all state updates on posedge
INIT  in  1  reset, asynchronous, active-high; clears all state
GO_SW  in  1  raw GO target contact, asynchronous
BOP_SW  in  1  raw BOP target contact, asynchronous
WHAM_SW  in  1  raw WHAM target contact, asynchronous
BASH_SW  in  1  raw BASH target contact, asynchronous
WIPE_SW  in  1  raw WIPE_OUT contact, asynchronous
LAUNCH_SW  in  1  raw plunger contact, asynchronous
NUDGE_SW  in  1  raw cabinet nudge sensor, asynchronous
TILT_CLR  in  1  synchronous one-cycle tilt clear from game control
GO_HIT, BOP_HIT, WHAM_HIT, BASH_HIT, WIPE_OUT_HIT  out  1 each  registered one-cycle hit pulses; at most one high per cycle
START_BALL  out  1  registered one-cycle launch pulse
TILT  out  1  registered latched tilt level

Behaviour:
- Reset (INIT=1, asynchronous): sync flops, debounced states, debounce counters, pending bits, nudge count and window timer all cleared to 0. All outputs are 0. Every switch is treated as open. Reset asserted mid-press drops any in-flight event, and the next press must show a fresh rising edge.
- Per switch: 2-flop synchronizer, then the debouncer. The counter increments while the synced value differs from the debounced state and resets to 0 whenever they agree. When the count reaches DEB_CYCLES-1 and the values still differ, the debounced state flips and the counter clears. A 0->1 flip of the debounced state produces a one-cycle internal event.
- Latency, raw stable edge to output pulse: DEB_CYCLES+3 cycles when no higher-priority hit is pending (7 cycles at default). Release edges produce no event.
- Hit arbitration: 5-bit pending register. A hit event sets its bit. Each cycle, the highest set bit is granted in the fixed order GO > BOP > WHAM > BASH > WIPE. The granted bit drives its HIT output on the next edge, and that bit is cleared.
- Repeat event on an already-pending bit: merged into the existing request, so one pulse is produced.
- New event arriving on the same cycle its bit is granted: set wins, and the bit stays pending for a second pulse.
- START_BALL: launch event is pulsed directly, independent of hit arbitration, with the same latency.
- Tilt: the first nudge event while the nudge count is 0 sets count=1 and timer=0. While count>0, the timer increments each cycle and each nudge increments count (saturating at TILT_NUDGES).
  - When count reaches TILT_NUDGES, TILT=1 on the next edge and stays latched.
  - When the timer reaches TILT_WINDOW-1 without triggering, count and timer clear. A nudge on that same expiry cycle starts a new window with count=1.
- While TILT=1: the pending register is held at 0, and all HIT and START_BALL outputs are 0. Debouncers keep running, so events occurring during tilt are discarded, never replayed.
- TILT_CLR=1 clears TILT, nudge count and timer on the next edge. If TILT_CLR coincides with a threshold nudge, clear wins.
- No combinational input-to-output paths. All outputs come from flops.

Decomposition:
- Package pinball_pkg holds:
  - hit index constants: GO=0, BOP=1, WHAM=2, BASH=3, WIPE=4
  - NUM_HITS=5
  - default DEB_CYCLES and TILT parameters, shared with the scoring FSM and testbench
- Sub-module switch_debounce (params DEB_CYCLES, DEB_W; ports CLK, INIT, raw, level, rise), instantiated 7 times. The top level contains the pending/arbiter and tilt logic.

Test Plan:
- Assert INIT mid-operation with BOP pending and TILT=1 -> all outputs 0 within the same cycle; no BOP_HIT after INIT deasserts.
- BOP_SW 0->1 held 20 cycles, DEB_CYCLES=4 -> exactly one BOP_HIT, 7 cycles after the raw edge; release produces no pulse.
- BOP_SW toggles every 2 cycles for 12 cycles, then stable 1 -> exactly one BOP_HIT, 7 cycles after it goes stable.
- GO_SW and BASH_SW rise on the same cycle -> GO_HIT at cycle t, BASH_HIT at t+1, never both high together.
- Three NUDGE presses 10 cycles apart -> TILT=1 one cycle after the third debounced edge. A WHAM press then produces no WHAM_HIT. TILT_CLR pulse -> TILT=0 on the next edge, and no WHAM_HIT is replayed.
- Two nudges, a 70-cycle gap, then a third nudge -> TILT stays 0 and the nudge count reads 1.

Source files
------------

// File: rtl/pinball_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pinball_pkg
//  Description : Shared constants for the pinball switch conditioner and the
//                downstream scoring FSM. Contains the hit index map, the
//                default debounce/tilt parameters, and the hit arbiter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pinball_pkg;

    // Hit index map. A lower index means a higher arbitration priority.
    localparam int GO       = 0;
    localparam int BOP      = 1;
    localparam int WHAM     = 2;
    localparam int BASH     = 3;
    localparam int WIPE     = 4;
    localparam int NUM_HITS = 5;

    // Default tuning, shared with the scorer and the testbench.
    localparam int DEF_DEB_CYCLES  = 4;
    localparam int DEF_DEB_W       = 3;
    localparam int DEF_TILT_NUDGES = 3;
    localparam int DEF_TILT_WINDOW = 64;
    localparam int DEF_WIN_W       = 7;

    // Isolates the lowest set request bit, which is the highest-priority hit.
    function automatic logic [NUM_HITS-1:0] grant_first(input logic [NUM_HITS-1:0] req);
        return req & (~req + NUM_HITS'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : Two-flop synchronizer followed by a counting debouncer for a
//                single raw contact. A change is accepted once the synced
//                value has differed from the debounced state for DEB_CYCLES
//                consecutive cycles.
//  Ports       : CLK   - system clock
//                INIT  - asynchronous active-high reset (switch seen as open)
//                raw   - raw asynchronous contact
//                level - debounced switch state
//                rise  - one-cycle pulse, high in the cycle before level
//                        goes 0->1
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 3
) (
    input  logic CLK,
    input  logic INIT,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [DEB_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_flip;

    assign w_differ = r_sync2 ^ r_level;
    assign w_flip   = w_differ && (r_cnt == DEB_W'(DEB_CYCLES - 1));

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + DEB_W'(1);
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign level = r_level;
    // Event is decoded from the flip condition itself so the downstream
    // pending register captures it on the same edge the level flips.
    assign rise  = w_flip & r_sync2;

endmodule
`default_nettype wire

// File: rtl/pinball_switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : pinball_switch_conditioner
//  Description : Conditions raw playfield contacts into clean one-cycle hit
//                pulses (serialized by fixed priority), a launch pulse and a
//                latched tilt level.
//  Ports       : CLK, INIT             - clock, async active-high reset
//                GO/BOP/WHAM/BASH/WIPE_SW, LAUNCH_SW, NUDGE_SW - raw contacts
//                TILT_CLR              - synchronous tilt clear
//                GO/BOP/WHAM/BASH/WIPE_OUT_HIT - one-hot-or-zero hit pulses
//                START_BALL            - launch pulse
//                TILT                  - latched tilt level
//  Revision    : 1.0 - initial release
// ============================================================================
module pinball_switch_conditioner
    import pinball_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int DEB_W       = DEF_DEB_W,
    parameter int TILT_NUDGES = DEF_TILT_NUDGES,
    parameter int TILT_WINDOW = DEF_TILT_WINDOW,
    parameter int WIN_W       = DEF_WIN_W
) (
    input  logic CLK,
    input  logic INIT,
    input  logic GO_SW,
    input  logic BOP_SW,
    input  logic WHAM_SW,
    input  logic BASH_SW,
    input  logic WIPE_SW,
    input  logic LAUNCH_SW,
    input  logic NUDGE_SW,
    input  logic TILT_CLR,
    output logic GO_HIT,
    output logic BOP_HIT,
    output logic WHAM_HIT,
    output logic BASH_HIT,
    output logic WIPE_OUT_HIT,
    output logic START_BALL,
    output logic TILT
);

    localparam int NUM_SW     = NUM_HITS + 2;
    localparam int LAUNCH_IDX = NUM_HITS;
    localparam int NUDGE_IDX  = NUM_HITS + 1;
    localparam int CNT_W      = $clog2(TILT_NUDGES + 1);

    logic [NUM_SW-1:0]   w_raw;
    logic [NUM_SW-1:0]   w_rise;
    logic [NUM_SW-1:0]   w_levels_unused;

    logic [NUM_HITS-1:0] r_pend;
    logic [NUM_HITS-1:0] r_hit;
    logic [NUM_HITS-1:0] w_grant;
    logic [NUM_HITS-1:0] w_pend_next;
    logic                r_launch_d;
    logic                r_start;
    logic                r_tilt;
    logic                w_tilt_next;
    logic                w_block;
    logic [CNT_W-1:0]    r_nudge_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [WIN_W-1:0]    r_timer;
    logic [WIN_W-1:0]    w_timer_next;
    logic                w_nudge;
    logic                w_window_end;

    assign w_raw = {NUDGE_SW, LAUNCH_SW, WIPE_SW, BASH_SW, WHAM_SW, BOP_SW, GO_SW};

    generate
        for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
            switch_debounce #(
                .DEB_CYCLES (DEB_CYCLES),
                .DEB_W      (DEB_W)
            ) u_deb (
                .CLK   (CLK),
                .INIT  (INIT),
                .raw   (w_raw[i]),
                .level (w_levels_unused[i]),
                .rise  (w_rise[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------ tilt
    assign w_nudge      = w_rise[NUDGE_IDX];
    assign w_window_end = (r_timer == WIN_W'(TILT_WINDOW - 1));
    // Clear dominates a coincident threshold.
    assign w_tilt_next  = !TILT_CLR && (r_tilt || (r_nudge_cnt == CNT_W'(TILT_NUDGES)));
    // Suppress on the edge tilt rises as well, so no pulse ever overlaps TILT.
    assign w_block      = r_tilt | w_tilt_next;

    always_comb begin
        w_cnt_next   = r_nudge_cnt;
        w_timer_next = r_timer;
        if (TILT_CLR) begin
            w_cnt_next   = '0;
            w_timer_next = '0;
        end else if ((r_nudge_cnt == '0) || w_window_end) begin
            // Idle or window just expired: a nudge here opens a fresh window.
            w_cnt_next   = w_nudge ? CNT_W'(1) : '0;
            w_timer_next = '0;
        end else begin
            w_timer_next = r_timer + WIN_W'(1);
            if (w_nudge && (r_nudge_cnt != CNT_W'(TILT_NUDGES)))
                w_cnt_next = r_nudge_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------ arbitration
    assign w_grant = grant_first(r_pend);
    // New events are OR-ed after the grant is removed: a re-hit on the bit
    // being granted stays pending for a second pulse.
    assign w_pend_next = w_block ? '0 : ((r_pend & ~w_grant) | w_rise[NUM_HITS-1:0]);

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            r_pend      <= '0;
            r_hit       <= '0;
            r_launch_d  <= 1'b0;
            r_start     <= 1'b0;
            r_tilt      <= 1'b0;
            r_nudge_cnt <= '0;
            r_timer     <= '0;
        end else begin
            r_pend      <= w_pend_next;
            r_hit       <= w_block ? '0 : w_grant;
            // Extra stage keeps launch latency equal to the hit path.
            r_launch_d  <= w_rise[LAUNCH_IDX] & ~w_block;
            r_start     <= r_launch_d & ~w_block;
            r_tilt      <= w_tilt_next;
            r_nudge_cnt <= w_cnt_next;
            r_timer     <= w_timer_next;
        end
    end

    assign GO_HIT       = r_hit[GO];
    assign BOP_HIT      = r_hit[BOP];
    assign WHAM_HIT     = r_hit[WHAM];
    assign BASH_HIT     = r_hit[BASH];
    assign WIPE_OUT_HIT = r_hit[WIPE];
    assign START_BALL   = r_start;
    assign TILT         = r_tilt;

endmodule
`default_nettype wire
